// File: rtl/demux_8_1_reg_pkg.sv
//------------------------------------------------------------------------------
// Module      : demux_8_1_reg_pkg
// Description : Shared byte-path constants: default widths and route-select encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package demux_8_1_reg_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_CNT_WIDTH = 8;

  // S active selects channel A, matching the companion 2:1 byte mux.
  localparam logic SEL_A = 1'b1;
  localparam logic SEL_B = 1'b0;

  function automatic logic sel_is_a(input logic s);
    return s == SEL_A;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_8_1_reg_slot.sv
//------------------------------------------------------------------------------
// Module      : demux_slot
// Description : One output channel: holding register, full flag and delivery counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux_slot
  import demux_8_1_reg_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [WIDTH-1:0]     i_value,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_value,
  output logic                 o_valid,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_can_accept
);

  logic                 r_full;
  logic [WIDTH-1:0]     r_data;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_drain;

  assign w_drain = r_full & i_ready;

  // A load in the same cycle as a drain keeps the slot full (back-to-back pass).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full  <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      if (i_load) begin
        r_full <= 1'b1;
        r_data <= i_value;
      end else if (w_drain) begin
        r_full <= 1'b0;
      end
      if (w_drain) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  assign o_value      = r_data;
  assign o_valid      = r_full;
  assign o_count      = r_count;
  assign o_can_accept = ~r_full | i_ready;

endmodule

`default_nettype wire

// File: rtl/demux_8_1_reg.sv
//------------------------------------------------------------------------------
// Module      : demux_8_1_reg
// Description : Registered 1-to-2 byte demultiplexer with per-channel counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux_8_1_reg
  import demux_8_1_reg_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in_value,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 S,
  output logic [WIDTH-1:0]     a_value,
  output logic                 a_valid,
  input  logic                 a_ready,
  output logic [WIDTH-1:0]     b_value,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [CNT_WIDTH-1:0] a_count,
  output logic [CNT_WIDTH-1:0] b_count
);

  logic w_sel_a;
  logic w_acc;
  logic w_load_a;
  logic w_load_b;
  logic w_a_can_accept;
  logic w_b_can_accept;

  assign w_sel_a  = sel_is_a(S);
  // in_ready depends only on S and the consumer readies, never on in_valid.
  assign in_ready = w_sel_a ? w_a_can_accept : w_b_can_accept;
  assign w_acc    = in_valid & in_ready;
  assign w_load_a = w_acc & w_sel_a;
  assign w_load_b = w_acc & ~w_sel_a;

  demux_slot #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot_a (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load_a),
    .i_value      (in_value),
    .i_ready      (a_ready),
    .o_value      (a_value),
    .o_valid      (a_valid),
    .o_count      (a_count),
    .o_can_accept (w_a_can_accept)
  );

  demux_slot #(
    .WIDTH     (WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_slot_b (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load_b),
    .i_value      (in_value),
    .i_ready      (b_ready),
    .o_value      (b_value),
    .o_valid      (b_valid),
    .o_count      (b_count),
    .o_can_accept (w_b_can_accept)
  );

endmodule

`default_nettype wire

// File: tb/tb_demux_8_1_reg.sv
//------------------------------------------------------------------------------
// Module      : tb_demux_8_1_reg
// Description : Self-checking bench for demux_8_1_reg (vector table, sequences, random vs model).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux_8_1_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_value;
  logic       in_valid;
  logic       in_ready;
  logic       S;
  logic [7:0] a_value, b_value;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [7:0] a_count, b_count;

  int checks   = 0;
  int failures = 0;

  // Reference state, index 1 = channel A, index 0 = channel B.
  bit         m_full [2];
  logic [7:0] m_data [2];
  int         m_cnt  [2];

  typedef struct {
    logic [7:0] val;
    bit         v, s, ar, br;
    bit         ir;
    bit         av;
    logic [7:0] aval;
    bit         bv;
    logic [7:0] bval;
    int         ac, bc;
  } vec_t;

  vec_t tv [14];

  always #5 clk = ~clk;

  demux_8_1_reg #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_value (in_value),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .S        (S),
    .a_value  (a_value),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_value  (b_value),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_full[c] = 1'b0;
      m_data[c] = 8'h00;
      m_cnt[c]  = 0;
    end
  endfunction

  function automatic bit model_in_ready(bit s, bit ar, bit br);
    bit rdy [2];
    rdy[1] = ar;
    rdy[0] = br;
    return !m_full[s] || rdy[s];
  endfunction

  task automatic cmp_model();
    chk("a_valid", a_valid, m_full[1]);
    chk("a_value", a_value, m_data[1]);
    chk("a_count", a_count, m_cnt[1]);
    chk("b_valid", b_valid, m_full[0]);
    chk("b_value", b_value, m_data[0]);
    chk("b_count", b_count, m_cnt[0]);
  endtask

  // One clock: drive, check in_ready, advance model and DUT, compare outputs.
  task automatic step(input logic [7:0] val, input bit v, input bit s, input bit ar, input bit br);
    bit         rdy [2];
    bit         acc;
    in_value = val;
    in_valid = v;
    S        = s;
    a_ready  = ar;
    b_ready  = br;
    rdy[1] = ar;
    rdy[0] = br;
    #1;
    chk("in_ready", in_ready, model_in_ready(s, ar, br));
    acc = v && model_in_ready(s, ar, br);
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (m_full[c] && rdy[c]) begin
        m_full[c] = 1'b0;
        m_cnt[c]  = (m_cnt[c] + 1) % 256;
      end
      if (acc && (int'(s) == c)) begin
        m_full[c] = 1'b1;
        m_data[c] = val;
      end
    end
    #1;
    cmp_model();
  endtask

  initial begin
    reset    = 1'b1;
    in_value = 8'h00;
    in_valid = 1'b0;
    S        = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    model_reset();

    //           val    v  s  ar br ir av aval   bv bval   ac bc
    tv[0]  = '{8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0};
    tv[1]  = '{8'hA5, 1, 1, 1, 0, 1, 1, 8'hA5, 0, 8'h00, 0, 0};
    tv[2]  = '{8'h00, 0, 1, 1, 0, 1, 0, 8'hA5, 0, 8'h00, 1, 0};
    tv[3]  = '{8'h3C, 1, 0, 0, 1, 1, 0, 8'hA5, 1, 8'h3C, 1, 0};
    tv[4]  = '{8'h00, 0, 0, 0, 1, 1, 0, 8'hA5, 0, 8'h3C, 1, 1};
    tv[5]  = '{8'h11, 1, 1, 0, 0, 1, 1, 8'h11, 0, 8'h3C, 1, 1};
    tv[6]  = '{8'h22, 1, 1, 0, 0, 0, 1, 8'h11, 0, 8'h3C, 1, 1};
    tv[7]  = '{8'h33, 1, 0, 0, 0, 1, 1, 8'h11, 1, 8'h33, 1, 1};
    tv[8]  = '{8'h22, 1, 1, 1, 0, 1, 1, 8'h22, 1, 8'h33, 2, 1};
    tv[9]  = '{8'h00, 0, 1, 1, 1, 1, 0, 8'h22, 0, 8'h33, 3, 2};
    tv[10] = '{8'h44, 1, 1, 0, 0, 1, 1, 8'h44, 0, 8'h33, 3, 2};
    tv[11] = '{8'h77, 1, 0, 1, 0, 1, 0, 8'h44, 1, 8'h77, 4, 2};
    tv[12] = '{8'h99, 0, 1, 0, 0, 1, 0, 8'h44, 1, 8'h77, 4, 2};
    tv[13] = '{8'h00, 0, 0, 1, 0, 0, 0, 8'h44, 1, 8'h77, 4, 2};

    @(posedge clk);
    #1;
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_b_valid", b_valid, 1'b0);
    chk("rst_a_value", a_value, 8'h00);
    chk("rst_b_value", b_value, 8'h00);
    chk("rst_a_count", a_count, 8'h00);
    chk("rst_b_count", b_count, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      in_value = tv[i].val;
      in_valid = tv[i].v;
      S        = tv[i].s;
      a_ready  = tv[i].ar;
      b_ready  = tv[i].br;
      #1;
      chk($sformatf("tv%0d_in_ready", i), in_ready, tv[i].ir);
      step(tv[i].val, tv[i].v, tv[i].s, tv[i].ar, tv[i].br);
      chk($sformatf("tv%0d_a_valid", i), a_valid, tv[i].av);
      chk($sformatf("tv%0d_a_value", i), a_value, tv[i].aval);
      chk($sformatf("tv%0d_b_valid", i), b_valid, tv[i].bv);
      chk($sformatf("tv%0d_b_value", i), b_value, tv[i].bval);
      chk($sformatf("tv%0d_a_count", i), a_count, tv[i].ac);
      chk($sformatf("tv%0d_b_count", i), b_count, tv[i].bc);
    end

    // Back-to-back stream of 16 bytes into A with the consumer always ready.
    step(8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(8'(i), 1, 1, 1, 1);
      chk("b2b_a_valid", a_valid, 1'b1);
      chk("b2b_a_value", a_value, 8'(i));
    end
    step(8'h00, 0, 1, 1, 1);
    chk("b2b_a_valid_end", a_valid, 1'b0);
    chk("b2b_a_count", a_count, 8'(4 + 16));

    // Counter wrap on B from a clean reset.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) step(8'(i), 1, 0, 0, 1);
    step(8'h00, 0, 0, 0, 1);
    chk("wrap_b_count0", b_count, 8'h00);
    chk("wrap_a_count", a_count, 8'h00);
    step(8'hEE, 1, 0, 0, 1);
    step(8'h00, 0, 0, 0, 1);
    chk("wrap_b_count1", b_count, 8'h01);
    chk("wrap_a_count1", a_count, 8'h00);

    // Asynchronous reset while A holds 0x5A and has a nonzero count.
    step(8'h01, 1, 1, 0, 0);
    step(8'h00, 0, 1, 1, 0);
    step(8'h5A, 1, 1, 0, 0);
    chk("pre_rst_a_value", a_value, 8'h5A);
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_a_valid", a_valid, 1'b0);
    chk("async_a_count", a_count, 8'h00);
    chk("async_b_count", b_count, 8'h00);
    chk("async_a_value", a_value, 8'h00);
    model_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    cmp_model();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
